// File: rtl/sync_fifo_reader.sv
// Read-side adapter: drains a registered-read FIFO into a first-word-fall-through valid/ready stream.
// Latency: fifo_re_o in cycle N gives m_valid_o in N+2, and 1 word/cycle is sustained while m_ready_i is high.
// Backpressure: a 2-entry buffer, with reads issued only when a slot is free on arrival. `SYNC_FIFO_READER_FLUSH_EN adds flush_i.
module sync_fifo_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
`ifdef SYNC_FIFO_READER_FLUSH_EN
    input  logic                  flush_i,
`endif
    input  logic                  fifo_empty_i,
    output logic                  fifo_re_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [1:0]            occ_o
);

    logic [DATA_WIDTH-1:0] slot_q [2];
    logic                  head_q;
    logic                  tail_q;
    logic                  inflight_q;
    logic [1:0]            occ_q;
    logic                  pop;
    logic                  flush;
    logic                  room;

`ifdef SYNC_FIFO_READER_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign m_valid_o = (occ_q != 2'd0);
    assign m_data_o  = slot_q[head_q];
    assign occ_o     = occ_q;
    assign pop       = m_valid_o && m_ready_i;

    // A word already in flight has a reserved slot, so it counts as occupied.
    assign room      = (occ_q + {1'b0, inflight_q}) < 2'd2;
    assign fifo_re_o = rst_ni && !flush && !fifo_empty_i && (room || pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot_q[0]  <= '0;
            slot_q[1]  <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
        end else if (flush) begin
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            inflight_q <= fifo_re_o;
            if (inflight_q) begin
                slot_q[tail_q] <= fifo_data_i;
                tail_q         <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: a queue-based source FIFO and buffer model, with randomized traffic and ready.
module tb_sync_fifo_reader;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fifo_empty;
    logic         fifo_re;
    logic [W-1:0] fifo_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic [1:0]   occ;
    logic         flush;

    always #5 clk = ~clk;

    sync_fifo_reader #(.DATA_WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
`ifdef SYNC_FIFO_READER_FLUSH_EN
        .flush_i      (flush),
`endif
        .fifo_empty_i (fifo_empty),
        .fifo_re_o    (fifo_re),
        .fifo_data_i  (fifo_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_data_o     (m_data),
        .occ_o        (occ)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] buf_m[$];
    logic       pend;
    logic [7:0] pend_w;
    logic       underflow;
    logic       obs_re, obs_vld, exp_re, exp_vld;
    logic [1:0] obs_occ, exp_occ;
    logic [7:0] obs_dat;

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
        sent_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Samples the DUT mid-cycle, then advances one clock and updates the source FIFO and buffer model.
    task automatic step();
        #1;
        obs_re  = fifo_re;
        obs_vld = m_valid;
        obs_occ = occ;
        obs_dat = m_data;
        exp_vld = (buf_m.size() != 0);
        exp_occ = 2'(buf_m.size());
        exp_re  = rst_n && !flush && (fifo_q.size() != 0) &&
                  (((buf_m.size() + int'(pend)) < 2) || (exp_vld && m_ready));
        @(posedge clk);
        #1;
        if (!rst_n || flush) begin
            buf_m.delete();
        end else begin
            if (exp_vld && m_ready) void'(buf_m.pop_front());
            if (pend) buf_m.push_back(pend_w);
        end
        pend = 1'b0;
        if (obs_re) begin
            if (fifo_q.size() == 0) begin
                underflow = 1'b1;
            end else begin
                fifo_data = fifo_q.pop_front();
                pend      = 1'b1;
                pend_w    = fifo_data;
            end
        end
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] w;
        rst_n = 1'b0;
        m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs_re !== 1'b0 || obs_vld !== 1'b0 || obs_occ !== 2'd0 || obs_dat !== 8'h00) begin
                n_bad++;
                $display("FAIL reset cyc%0d: re/vld/occ/dat=%b/%b/%0d/%h want 0/0/0/00", i, obs_re, obs_vld, obs_occ, obs_dat);
            end
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (obs_re !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_re: re=%b want 1", obs_re);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (obs_re !== exp_re || obs_vld !== exp_vld || obs_occ !== exp_occ) begin
                n_bad++;
                $display("FAIL reset_drain cyc%0d: re/vld/occ=%b/%b/%0d want %b/%b/%0d", i, obs_re, obs_vld, obs_occ, exp_re, exp_vld, exp_occ);
            end
            if (exp_vld && m_ready && sent_q.size() != 0) begin
                w = sent_q.pop_front();
                n_cmp++;
                if (obs_dat !== w) begin
                    n_bad++;
                    $display("FAIL reset_data: got %h want %h", obs_dat, w);
                end
            end
        end
    endtask

    task automatic test_latency();
        m_ready = 1'b1;
        push(8'hA5);
        step();
        n_cmp++;
        if (obs_re !== 1'b1 || obs_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL lat_c0: re/vld=%b/%b want 1/0", obs_re, obs_vld);
        end
        step();
        n_cmp++;
        if (obs_vld !== 1'b0 || obs_re !== 1'b0) begin
            n_bad++;
            $display("FAIL lat_c1: vld/re=%b/%b want 0/0", obs_vld, obs_re);
        end
        step();
        void'(sent_q.pop_front());
        n_cmp++;
        if (obs_vld !== 1'b1 || obs_dat !== 8'hA5 || obs_occ !== 2'd1) begin
            n_bad++;
            $display("FAIL lat_c2: vld/dat/occ=%b/%h/%0d want 1/a5/1", obs_vld, obs_dat, obs_occ);
        end
        step();
        n_cmp++;
        if (obs_occ !== 2'd0 || obs_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL lat_c3: occ/vld=%0d/%b want 0/0", obs_occ, obs_vld);
        end
    endtask

    task automatic test_stream();
        int first, last, cnt;
        logic [7:0] w;
        first = -1; last = -1; cnt = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        for (int c = 0; c < 30; c++) begin
            step();
            n_cmp++;
            if (obs_re !== exp_re || obs_vld !== exp_vld || obs_occ !== exp_occ) begin
                n_bad++;
                $display("FAIL stream_ctl cyc%0d: re/vld/occ=%b/%b/%0d want %b/%b/%0d", c, obs_re, obs_vld, obs_occ, exp_re, exp_vld, exp_occ);
            end
            if (obs_vld === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
            if (exp_vld && sent_q.size() != 0) begin
                w = sent_q.pop_front();
                n_cmp++;
                if (obs_dat !== w) begin
                    n_bad++;
                    $display("FAIL stream_data: got %h want %h", obs_dat, w);
                end
            end
        end
        n_cmp++;
        if (cnt != 16 || (last - first + 1) != 16 || underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_run: words=%0d span=%0d underflow=%b want 16/16/0", cnt, last - first + 1, underflow);
        end
    endtask

    task automatic test_backpressure();
        logic       prev_stall;
        logic [7:0] prev_dat, w;
        int         cnt;
        prev_stall = 1'b0; prev_dat = 8'h00; cnt = 0;
        for (int i = 0; i < 16; i++) push(8'(i));
        for (int c = 0; c < 80; c++) begin
            m_ready = (c % 4 == 0) || (c % 4 == 3);
            step();
            n_cmp++;
            if (obs_re !== exp_re || obs_vld !== exp_vld || obs_occ !== exp_occ || obs_occ > 2'd2) begin
                n_bad++;
                $display("FAIL bp_ctl cyc%0d: re/vld/occ=%b/%b/%0d want %b/%b/%0d", c, obs_re, obs_vld, obs_occ, exp_re, exp_vld, exp_occ);
            end
            if (prev_stall) begin
                n_cmp++;
                if (obs_vld !== 1'b1 || obs_dat !== prev_dat) begin
                    n_bad++;
                    $display("FAIL bp_stable: vld/dat=%b/%h want 1/%h", obs_vld, obs_dat, prev_dat);
                end
            end
            prev_stall = obs_vld && !m_ready;
            prev_dat   = obs_dat;
            if (exp_vld && m_ready && sent_q.size() != 0) begin
                w = sent_q.pop_front();
                cnt++;
                n_cmp++;
                if (obs_dat !== w) begin
                    n_bad++;
                    $display("FAIL bp_data: got %h want %h", obs_dat, w);
                end
            end
        end
        n_cmp++;
        if (cnt != 16 || sent_q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_count: delivered=%0d left=%0d want 16/0", cnt, sent_q.size());
        end
    endtask

    task automatic test_empty_edge();
        m_ready = 1'b0;
        push(8'h40); push(8'h41);
        for (int c = 0; c < 4; c++) step();
        n_cmp++;
        if (obs_occ !== 2'd2 || obs_re !== 1'b0 || obs_dat !== 8'h40) begin
            n_bad++;
            $display("FAIL empty_full: occ/re/dat=%0d/%b/%h want 2/0/40", obs_occ, obs_re, obs_dat);
        end
        m_ready = 1'b1;
        step();
        n_cmp++;
        if (obs_re !== 1'b0 || obs_vld !== 1'b1 || obs_dat !== 8'h40) begin
            n_bad++;
            $display("FAIL empty_pop0: re/vld/dat=%b/%b/%h want 0/1/40", obs_re, obs_vld, obs_dat);
        end
        step();
        n_cmp++;
        if (obs_re !== 1'b0 || obs_vld !== 1'b1 || obs_dat !== 8'h41) begin
            n_bad++;
            $display("FAIL empty_pop1: re/vld/dat=%b/%b/%h want 0/1/41", obs_re, obs_vld, obs_dat);
        end
        step();
        void'(sent_q.pop_front());
        void'(sent_q.pop_front());
        n_cmp++;
        if (obs_vld !== 1'b0 || obs_occ !== 2'd0) begin
            n_bad++;
            $display("FAIL empty_done: vld/occ=%b/%0d want 0/0", obs_vld, obs_occ);
        end
    endtask

    task automatic test_random();
        logic [7:0] w;
        for (int c = 0; c < 420; c++) begin
            if (c < 400 && $urandom_range(0, 1) == 1 && fifo_q.size() < 8) push(8'($urandom));
            m_ready = (c >= 400) || ($urandom_range(0, 3) != 0);
            step();
            n_cmp++;
            if (obs_re !== exp_re || obs_vld !== exp_vld || obs_occ !== exp_occ) begin
                n_bad++;
                $display("FAIL rand_ctl cyc%0d: re/vld/occ=%b/%b/%0d want %b/%b/%0d", c, obs_re, obs_vld, obs_occ, exp_re, exp_vld, exp_occ);
            end
            if (exp_vld && m_ready && sent_q.size() != 0) begin
                w = sent_q.pop_front();
                n_cmp++;
                if (obs_dat !== w) begin
                    n_bad++;
                    $display("FAIL rand_data cyc%0d: got %h want %h", c, obs_dat, w);
                end
            end
        end
        n_cmp++;
        if (sent_q.size() != 0 || underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL rand_end: left=%0d underflow=%b want 0/0", sent_q.size(), underflow);
        end
    endtask

`ifdef SYNC_FIFO_READER_FLUSH_EN
    task automatic test_flush();
        logic [7:0] w;
        m_ready = 1'b0;
        push(8'h30); push(8'h31); push(8'h32); push(8'h33);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++;
        if (obs_re !== 1'b0 || obs_occ !== 2'd1) begin
            n_bad++;
            $display("FAIL flush_cyc: re/occ=%b/%0d want 0/1", obs_re, obs_occ);
        end
        void'(sent_q.pop_front());
        void'(sent_q.pop_front());
        step();
        n_cmp++;
        if (obs_vld !== 1'b0 || obs_occ !== 2'd0) begin
            n_bad++;
            $display("FAIL flush_after: vld/occ=%b/%0d want 0/0", obs_vld, obs_occ);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (exp_vld && sent_q.size() != 0) begin
                w = sent_q.pop_front();
                n_cmp++;
                if (obs_dat !== w) begin
                    n_bad++;
                    $display("FAIL flush_data: got %h want %h", obs_dat, w);
                end
            end
        end
        n_cmp++;
        if (sent_q.size() != 0) begin
            n_bad++;
            $display("FAIL flush_left: %0d words undelivered want 0", sent_q.size());
        end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        pend       = 1'b0;
        pend_w     = 8'h00;
        underflow  = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_stream();
        test_backpressure();
        test_empty_edge();
        test_random();
`ifdef SYNC_FIFO_READER_FLUSH_EN
        test_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
